// File: rtl/fifo_ptr_sync_gen.sv
// Per-domain async FIFO pointer engine: local binary/Gray pointer, memory address,
// and a synchronized, binary-converted copy of the remote Gray pointer.
module fifo_ptr_sync_gen #(
  parameter int    DEL           = 1,
  parameter int    ADDR_WIDTH    = 3,
  parameter int    DEPTH         = 8,
  parameter int    SYNC_STAGES   = 2,
  parameter string INSTANCE_NAME = "DEADF1F0"
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_inc,
  input  logic                  i_block,
  input  logic [ADDR_WIDTH:0]   i_remote_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_ptr_bin,
  output logic [ADDR_WIDTH:0]   o_ptr_gray,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH:0]   o_remote_ptr_bin,
  output logic                  o_adv,
  output logic                  o_err
);

  localparam int AW = ADDR_WIDTH;

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "%s: DEPTH must equal 2**ADDR_WIDTH", INSTANCE_NAME);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "%s: SYNC_STAGES must be >= 2", INSTANCE_NAME);
  end
  if (DEL < 0) begin : g_bad_del
    $fatal(1, "%s: DEL must be non-negative", INSTANCE_NAME);
  end

  logic          adv;
  logic [AW:0]   nxt;
  logic [AW:0]   sync_q [SYNC_STAGES];
  logic [AW:0]   remote_bin;

  always_comb begin
    adv = i_inc & ~i_block;
    nxt = adv ? o_ptr_bin + 1'b1 : o_ptr_bin;
  end

  // Gray is registered from the next binary value so both update on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr_bin  <= '0;
      o_ptr_gray <= '0;
      o_adv      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_ptr_bin  <= nxt;
      o_ptr_gray <= nxt ^ (nxt >> 1);
      o_adv      <= adv;
      o_err      <= o_err | (i_inc & i_block);
    end
  end

  assign o_addr = o_ptr_bin[AW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_remote_ptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // b[i] is the XOR of all Gray bits at or above i
  always_comb begin
    remote_bin = '0;
    for (int unsigned i = 0; i <= AW; i++) remote_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_remote_ptr_bin <= '0;
    else          o_remote_ptr_bin <= remote_bin;
  end

endmodule

// File: tb/tb_fifo_ptr_sync_gen.sv
// Directed bench for fifo_ptr_sync_gen: table of advance vectors plus hand-written
// sequences for reset, blocking, remote synchronization and mid-stream reset.
module tb_fifo_ptr_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       block = 1'b0;
  logic [3:0] remote_gray = '0;
  logic [3:0] ptr_bin, ptr_gray, remote_bin;
  logic [2:0] addr;
  logic       adv, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_ptr_sync_gen #(
    .DEL(1), .ADDR_WIDTH(3), .DEPTH(8), .SYNC_STAGES(2), .INSTANCE_NAME("TBPTR")
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc), .i_block(block),
    .i_remote_ptr_gray(remote_gray), .o_ptr_bin(ptr_bin), .o_ptr_gray(ptr_gray),
    .o_addr(addr), .o_remote_ptr_bin(remote_bin), .o_adv(adv), .o_err(err)
  );

  typedef struct {
    logic       inc;
    logic       block;
    logic [3:0] ptr;
    logic [3:0] gray;
    logic [2:0] addr;
    logic       adv;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inc = 1'b0;
    block = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] grays [16];
    logic [3:0] prev;
    grays = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 4'((i + 1) % 16), grays[i], 3'((i + 1) % 8), 1'b1};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 1'b0};

    // 1: asynchronous reset with nonzero state
    @(posedge clk);
    #1 rst_n = 1'b1;
    remote_gray = 4'b0101;
    inc = 1'b1;
    edge_sample();
    edge_sample();
    inc = 1'b0;
    edge_sample();
    edge_sample();
    chk("pre_reset_ptr", 32'(ptr_bin), 32'h2);
    chk("pre_reset_remote", 32'(remote_bin), 32'h6);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ptr", 32'(ptr_bin), 32'h0);
    chk("async_rst_gray", 32'(ptr_gray), 32'h0);
    chk("async_rst_addr", 32'(addr), 32'h0);
    chk("async_rst_remote", 32'(remote_bin), 32'h0);
    chk("async_rst_adv_err", {30'h0, adv, err}, 32'h0);
    remote_gray = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2/3: table of 16 back-to-back advances then an idle cycle
    prev = ptr_gray;
    for (int i = 0; i < 17; i++) begin
      inc = vecs[i].inc;
      block = vecs[i].block;
      edge_sample();
      chk($sformatf("vec%0d_ptr", i), 32'(ptr_bin), 32'(vecs[i].ptr));
      chk($sformatf("vec%0d_gray", i), 32'(ptr_gray), 32'(vecs[i].gray));
      chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_adv", i), 32'(adv), 32'(vecs[i].adv));
      chk($sformatf("vec%0d_b2g", i), 32'(ptr_gray), 32'(ptr_bin ^ (ptr_bin >> 1)));
      if (vecs[i].adv)
        chk($sformatf("vec%0d_hamming", i), 32'($countones(prev ^ ptr_gray)), 32'd1);
      prev = ptr_gray;
    end
    chk("no_err_after_table", 32'(err), 32'h0);

    // 4: blocked request at pointer 5
    do_reset();
    inc = 1'b1;
    for (int i = 0; i < 5; i++) edge_sample();
    chk("blk_pre_ptr", 32'(ptr_bin), 32'h5);
    block = 1'b1;
    edge_sample();
    chk("blk_ptr", 32'(ptr_bin), 32'h5);
    chk("blk_adv", 32'(adv), 32'h0);
    chk("blk_err", 32'(err), 32'h1);
    inc = 1'b0;
    block = 1'b0;
    edge_sample();
    edge_sample();
    chk("blk_err_sticky", 32'(err), 32'h1);
    chk("blk_ptr_hold", 32'(ptr_bin), 32'h5);
    do_reset();
    chk("blk_err_cleared", 32'(err), 32'h0);

    // 5: remote synchronizer latency of 3 edges
    begin
      logic [3:0] rin  [3];
      logic [3:0] rexp [3];
      logic [3:0] rold;
      rin  = '{4'b0001, 4'b0011, 4'b0010};
      rexp = '{4'h1, 4'h2, 4'h3};
      rold = 4'h0;
      for (int i = 0; i < 3; i++) begin
        remote_gray = rin[i];
        edge_sample();
        edge_sample();
        chk($sformatf("sync%0d_edge2", i), 32'(remote_bin), 32'(rold));
        edge_sample();
        chk($sformatf("sync%0d_edge3", i), 32'(remote_bin), 32'(rexp[i]));
        rold = rexp[i];
      end
    end

    // 6: mid-stream reset at pointer 11
    do_reset();
    inc = 1'b1;
    for (int i = 0; i < 11; i++) edge_sample();
    chk("mid_pre_ptr", 32'(ptr_bin), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ptr", 32'(ptr_bin), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_sample();
    chk("mid_first_ptr", 32'(ptr_bin), 32'h1);
    chk("mid_first_gray", 32'(ptr_gray), 32'h1);
    inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
